// File: rtl/arb_rr.sv
// -----------------------------------------------------------------------------
// pry2thr -- priority-to-thermometer conversion
//
// Purpose
//   Turns a priority vector into a thermometer: every position at or beyond
//   the first set bit (counted in the rotation direction) is set.
//   DIRECTION "LSB": thr[i] = |pry[i:0]
//   DIRECTION "MSB": thr[i] = |pry[WIDTH-1:i]
//   An all-zero input yields an all-zero thermometer.
//
// Ports
//   pry  in   WIDTH  priority vector
//   thr  out  WIDTH  thermometer
//
// Parameters
//   WIDTH           vector width
//   SPLIT           segment width used by the loop implementation
//   DIRECTION       "LSB" or "MSB"
//   IMPLEMENTATION  0 segmented loop, 1 log-step vector OR, 2 adder trick
// -----------------------------------------------------------------------------
module pry2thr #(
  parameter int    WIDTH          = 9,
  parameter int    SPLIT          = 3,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] thr
);

  localparam bit MSB = (DIRECTION == "MSB");

  // All three implementations compute the LSB-ascending form; the MSB form
  // is obtained by bit-reversing the input and the output around it.
  logic [WIDTH-1:0] pry_l;
  logic [WIDTH-1:0] thr_l;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    if (MSB) begin : g_msb
      assign pry_l[i] = pry[WIDTH-1-i];
      assign thr[i]   = thr_l[WIDTH-1-i];
    end else begin : g_lsb
      assign pry_l[i] = pry[i];
      assign thr[i]   = thr_l[i];
    end
  end

  if (IMPLEMENTATION == 0) begin : g_loop
    // Segmented prefix OR: each SPLIT-wide segment first reports whether it
    // holds any set bit, those flags ripple into per-segment carries, and the
    // ripple inside a segment starts from its carry. The input is zero-padded
    // up to a whole number of segments.
    localparam int SEGS = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int PW   = SEGS * SPLIT;

    logic [PW-1:0]   pry_p;
    logic [PW-1:0]   thr_p;
    logic [SEGS-1:0] seg_any;
    logic [SEGS-1:0] seg_cin;
    logic            run;

    assign pry_p = PW'(pry_l);

    always_comb begin
      seg_any = '0;
      seg_cin = '0;
      thr_p   = '0;
      run     = 1'b0;
      for (int s = 0; s < SEGS; s++) begin
        seg_any[s] = |pry_p[s*SPLIT +: SPLIT];
      end
      for (int s = 1; s < SEGS; s++) begin
        seg_cin[s] = seg_cin[s-1] | seg_any[s-1];
      end
      for (int s = 0; s < SEGS; s++) begin
        run = seg_cin[s];
        for (int b = 0; b < SPLIT; b++) begin
          run = run | pry_p[s*SPLIT + b];
          thr_p[s*SPLIT + b] = run;
        end
      end
    end

    assign thr_l = thr_p[WIDTH-1:0];
  end else if (IMPLEMENTATION == 1) begin : g_vector
    // Log-step prefix OR: after the step with shift k, every bit already
    // covers the 2k positions below it.
    always_comb begin
      thr_l = pry_l;
      for (int k = 1; k < WIDTH; k = k * 2) begin
        thr_l = thr_l | (thr_l << k);
      end
    end
  end else begin : g_adder
    // Isolate the lowest set bit with x & -x; subtracting one from it gives
    // ones strictly below, so the inverse is ones at and above. A zero input
    // gives low = 0, low - 1 = all ones, and therefore thr = 0.
    logic [WIDTH-1:0] low;
    assign low   = pry_l & (~pry_l + WIDTH'(1));
    assign thr_l = ~(low - WIDTH'(1));
  end

endmodule

// -----------------------------------------------------------------------------
// arb_rr -- registered round-robin arbiter with a valid/ready grant port
//
// Purpose
//   Picks one requester per handshake, rotating priority past the index of
//   the last accepted grant. Sits in front of shared-resource muxes.
//
// Ports
//   clk      in   1              clock, rising edge
//   rst      in   1              synchronous reset, active-high
//   req      in   WIDTH          level requests
//   gnt_vld  out  1              grant valid
//   gnt_rdy  in   1              consumer accepts the grant
//   gnt      out  WIDTH          one-hot grant, zero when gnt_vld=0
//   gnt_idx  out  $clog2(WIDTH)  binary index of gnt, zero when gnt_vld=0
//
// Handshake: a grant transfers on every rising edge where gnt_vld && gnt_rdy.
// While gnt_vld=1 and gnt_rdy=0 the grant (gnt, gnt_idx) is held unchanged
// and req is not sampled; the slot is free to load a new selection whenever
// gnt_vld=0 or gnt_rdy=1, so an accepted grant can be replaced the same cycle.
// -----------------------------------------------------------------------------
module arb_rr #(
  parameter int    WIDTH          = 9,
  parameter int    SPLIT          = 3,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  output logic                     gnt_vld,
  input  logic                     gnt_rdy,
  output logic [WIDTH-1:0]         gnt,
  output logic [$clog2(WIDTH)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam bit MSB   = (DIRECTION == "MSB");

  // Rotation pointer: index of the last accepted grant. ptr_vld=0 means no
  // grant has been accepted since reset, so every requester is eligible and
  // the lowest (LSB) or highest (MSB) index wins.
  logic             ptr_vld;
  logic [IDX_W-1:0] ptr_idx;

  logic             free;
  logic             hsk;
  logic             eff_vld;
  logic [IDX_W-1:0] eff_idx;

  logic [WIDTH-1:0] ptr_oh;
  logic [WIDTH-1:0] ptr_thr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] elig;
  logic [WIDTH-1:0] thr_e;
  logic [WIDTH-1:0] thr_r;
  logic [WIDTH-1:0] thr_sel;
  logic [WIDTH-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;

  assign free = !gnt_vld || gnt_rdy;
  assign hsk  = gnt_vld && gnt_rdy;

  // Selection must see the pointer as updated by a handshake in this same
  // cycle, otherwise back-to-back grants would repeat the accepted winner.
  assign eff_vld = hsk ? 1'b1    : ptr_vld;
  assign eff_idx = hsk ? gnt_idx : ptr_idx;

  always_comb begin
    ptr_oh = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ptr_oh[i] = eff_vld && (eff_idx == IDX_W'(i));
    end
  end

  // Thermometer of the pointer covers the pointer and everything beyond it
  // in rotation order; dropping the pointer bit leaves the strictly-later
  // positions (indices > g for LSB, < g for MSB).
  pry2thr #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_mask (
    .pry(ptr_oh),
    .thr(ptr_thr)
  );

  assign mask = eff_vld ? (ptr_thr & ~ptr_oh) : '1;
  assign elig = req & mask;

  pry2thr #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_thr_elig (
    .pry(elig),
    .thr(thr_e)
  );

  pry2thr #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_thr_req (
    .pry(req),
    .thr(thr_r)
  );

  // Nobody beyond the pointer is requesting: wrap to the full request set.
  assign thr_sel = (|elig) ? thr_e : thr_r;

  // The thermometer edge is the winner.
  assign win_oh = MSB ? (thr_sel & ~(thr_sel >> 1))
                      : (thr_sel & ~(thr_sel << 1));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (win_oh[i]) begin
        win_idx = win_idx | IDX_W'(i);
      end
    end
  end

  // req only reaches state through the free-gated load, so an unknown req
  // during a stalled grant cannot disturb the held outputs or the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_vld <= 1'b0;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr_vld <= 1'b0;
      ptr_idx <= '0;
    end else begin
      if (hsk) begin
        ptr_vld <= 1'b1;
        ptr_idx <= gnt_idx;
      end
      if (free) begin
        gnt_vld <= |win_oh;
        gnt     <= win_oh;
        gnt_idx <= win_idx;
      end
    end
  end

endmodule
